// File: rtl/game_pkg.sv
// Shared game types: movement directions, player step states and tile timing constants.
package game_pkg;

   typedef enum logic [1:0] {
      DOWN  = 2'd0,
      UP    = 2'd1,
      LEFT  = 2'd2,
      RIGHT = 2'd3
   } dir_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOOKUP = 2'd1,
      ST_STEP   = 2'd2,
      ST_BUMP   = 2'd3
   } step_state_t;

   localparam int TILE_PX        = 16;
   localparam int HALF_TILE_PX   = TILE_PX / 2;
   localparam int LOOKUP_TIMEOUT = 255;

   // Neighbour tile one step toward d, widened to 7 bits so that stepping off
   // either edge lands at >= the map size (0 - 1 wraps to 127).
   function automatic logic [13:0] step_target(input logic [5:0] x,
                                               input logic [5:0] y,
                                               input dir_t       d);
      logic [6:0] nx;
      logic [6:0] ny;
      nx = {1'b0, x};
      ny = {1'b0, y};
      case (d)
         DOWN:    ny = {1'b0, y} + 7'd1;
         UP:      ny = {1'b0, y} - 7'd1;
         LEFT:    nx = {1'b0, x} - 7'd1;
         RIGHT:   nx = {1'b0, x} + 7'd1;
         default: nx = {1'b0, x};
      endcase
      return {nx, ny};
   endfunction

endpackage

// File: rtl/player_step_ctrl.sv
// Tile-based player movement: per-frame stepping with an external collision
// lookup over a req/ack handshake, bump animation when blocked or at map edge.
module player_step_ctrl
   import game_pkg::*;
#(
   parameter int MAP_W   = 40,
   parameter int MAP_H   = 30,
   parameter int START_X = 10,
   parameter int START_Y = 10
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_tick,
   input  logic       move_req,
   input  logic [1:0] move_dir,
   input  logic       run,
   output logic       coll_req,
   output logic [5:0] coll_x,
   output logic [5:0] coll_y,
   input  logic       coll_ack,
   input  logic       coll_blocked,
   output logic [5:0] tile_x,
   output logic [5:0] tile_y,
   output logic [3:0] pix_off,
   output logic [1:0] facing,
   output logic       walking,
   output logic [1:0] anim_frame
);

   localparam logic [6:0] MAP_W_C   = 7'(MAP_W);
   localparam logic [6:0] MAP_H_C   = 7'(MAP_H);
   localparam logic [5:0] START_X_C = 6'(START_X);
   localparam logic [5:0] START_Y_C = 6'(START_Y);
   localparam logic [4:0] TILE_C    = 5'(TILE_PX);
   localparam logic [4:0] HALF_C    = 5'(HALF_TILE_PX);
   localparam logic [4:0] BUMP_LAST = 5'(TILE_PX - 1);
   localparam logic [7:0] TMO_LAST  = 8'(LOOKUP_TIMEOUT - 1);

   step_state_t state_r, state_nx;
   logic [5:0]  tile_x_r, tile_x_nx;
   logic [5:0]  tile_y_r, tile_y_nx;
   logic [1:0]  facing_r, facing_nx;
   logic        run_lat_r, run_lat_nx;
   logic [4:0]  offset_r, offset_nx;
   logic [4:0]  bump_cnt_r, bump_cnt_nx;
   logic        parity_r, parity_nx;
   logic [7:0]  timeout_r, timeout_nx;
   logic        coll_req_r, coll_req_nx;
   logic [5:0]  coll_x_r, coll_x_nx;
   logic [5:0]  coll_y_r, coll_y_nx;
   logic [3:0]  pix_off_r, pix_off_nx;
   logic        walking_r, walking_nx;
   logic [1:0]  anim_frame_r, anim_frame_nx;

   logic [1:0]  dir_sel_s;
   logic [13:0] target_s;
   logic        oob_s;
   logic [4:0]  offset_sum_s;
   logic [1:0]  first_half_frame_s;

   // Neighbour tile: requested direction while idle, committed facing otherwise.
   always_comb begin
      if (state_r == ST_IDLE) begin
         dir_sel_s = move_dir;
      end else begin
         dir_sel_s = facing_r;
      end
      target_s           = step_target(tile_x_r, tile_y_r, dir_t'(dir_sel_s));
      oob_s              = (target_s[13:7] >= MAP_W_C) || (target_s[6:0] >= MAP_H_C);
      offset_sum_s       = offset_r + (run_lat_r ? 5'd2 : 5'd1);
      first_half_frame_s = parity_r ? 2'd2 : 2'd1;
   end

   // Next-state and next-output logic for the step FSM.
   always_comb begin
      state_nx    = state_r;
      tile_x_nx   = tile_x_r;
      tile_y_nx   = tile_y_r;
      facing_nx   = facing_r;
      run_lat_nx  = run_lat_r;
      offset_nx   = offset_r;
      bump_cnt_nx = bump_cnt_r;
      parity_nx   = parity_r;
      timeout_nx  = timeout_r;
      coll_req_nx = coll_req_r;
      coll_x_nx   = coll_x_r;
      coll_y_nx   = coll_y_r;

      case (state_r)
         ST_IDLE: begin
            if (frame_tick && move_req) begin
               facing_nx  = move_dir;
               run_lat_nx = run;
               if (oob_s) begin
                  state_nx    = ST_BUMP;
                  bump_cnt_nx = 5'd0;
               end else begin
                  state_nx    = ST_LOOKUP;
                  coll_req_nx = 1'b1;
                  coll_x_nx   = target_s[12:7];
                  coll_y_nx   = target_s[5:0];
                  timeout_nx  = 8'd0;
               end
            end else begin
               state_nx = ST_IDLE;
            end
         end

         ST_LOOKUP: begin
            if (coll_ack) begin
               coll_req_nx = 1'b0;
               timeout_nx  = 8'd0;
               if (coll_blocked) begin
                  state_nx    = ST_BUMP;
                  bump_cnt_nx = 5'd0;
               end else begin
                  state_nx  = ST_STEP;
                  offset_nx = 5'd0;
               end
            end else if (timeout_r == TMO_LAST) begin
               // A silent collision memory is treated as a wall.
               coll_req_nx = 1'b0;
               timeout_nx  = 8'd0;
               state_nx    = ST_BUMP;
               bump_cnt_nx = 5'd0;
            end else begin
               timeout_nx = timeout_r + 8'd1;
            end
         end

         ST_STEP: begin
            if (frame_tick) begin
               if (offset_sum_s >= TILE_C) begin
                  tile_x_nx = target_s[12:7];
                  tile_y_nx = target_s[5:0];
                  offset_nx = 5'd0;
                  parity_nx = ~parity_r;
                  state_nx  = ST_IDLE;
               end else begin
                  offset_nx = offset_sum_s;
               end
            end else begin
               state_nx = ST_STEP;
            end
         end

         ST_BUMP: begin
            if (frame_tick) begin
               if (bump_cnt_r == BUMP_LAST) begin
                  bump_cnt_nx = 5'd0;
                  state_nx    = ST_IDLE;
               end else begin
                  bump_cnt_nx = bump_cnt_r + 5'd1;
               end
            end else begin
               state_nx = ST_BUMP;
            end
         end

         default: begin
            state_nx    = ST_IDLE;
            coll_req_nx = 1'b0;
            offset_nx   = 5'd0;
            bump_cnt_nx = 5'd0;
         end
      endcase
   end

   // Presentation outputs derived from the upcoming state so they register with it.
   always_comb begin
      pix_off_nx    = 4'd0;
      walking_nx    = 1'b0;
      anim_frame_nx = 2'd0;
      case (state_nx)
         ST_STEP: begin
            pix_off_nx    = offset_nx[3:0];
            walking_nx    = 1'b1;
            anim_frame_nx = (offset_nx < HALF_C) ? first_half_frame_s : 2'd0;
         end
         ST_BUMP: begin
            walking_nx    = 1'b1;
            anim_frame_nx = (bump_cnt_nx < HALF_C) ? first_half_frame_s : 2'd0;
         end
         default: begin
            walking_nx = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_r      <= ST_IDLE;
         tile_x_r     <= START_X_C;
         tile_y_r     <= START_Y_C;
         facing_r     <= 2'd0;
         run_lat_r    <= 1'b0;
         offset_r     <= 5'd0;
         bump_cnt_r   <= 5'd0;
         parity_r     <= 1'b0;
         timeout_r    <= 8'd0;
         coll_req_r   <= 1'b0;
         coll_x_r     <= 6'd0;
         coll_y_r     <= 6'd0;
         pix_off_r    <= 4'd0;
         walking_r    <= 1'b0;
         anim_frame_r <= 2'd0;
      end else begin
         state_r      <= state_nx;
         tile_x_r     <= tile_x_nx;
         tile_y_r     <= tile_y_nx;
         facing_r     <= facing_nx;
         run_lat_r    <= run_lat_nx;
         offset_r     <= offset_nx;
         bump_cnt_r   <= bump_cnt_nx;
         parity_r     <= parity_nx;
         timeout_r    <= timeout_nx;
         coll_req_r   <= coll_req_nx;
         coll_x_r     <= coll_x_nx;
         coll_y_r     <= coll_y_nx;
         pix_off_r    <= pix_off_nx;
         walking_r    <= walking_nx;
         anim_frame_r <= anim_frame_nx;
      end
   end

   assign coll_req   = coll_req_r;
   assign coll_x     = coll_x_r;
   assign coll_y     = coll_y_r;
   assign tile_x     = tile_x_r;
   assign tile_y     = tile_y_r;
   assign pix_off    = pix_off_r;
   assign facing     = facing_r;
   assign walking    = walking_r;
   assign anim_frame = anim_frame_r;

endmodule

// File: tb/tb_player_step_ctrl.sv
// Scoreboarded bench for player_step_ctrl: walk, run, blocked, timeout,
// back-to-back steps to the map edge, edge bump and reset mid-step.
module tb_player_step_ctrl;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       frame_tick = 1'b0;
   logic       move_req = 1'b0;
   logic [1:0] move_dir = 2'd0;
   logic       run = 1'b0;
   logic       coll_req;
   logic [5:0] coll_x;
   logic [5:0] coll_y;
   logic       coll_ack = 1'b0;
   logic       coll_blocked = 1'b0;
   logic [5:0] tile_x;
   logic [5:0] tile_y;
   logic [3:0] pix_off;
   logic [1:0] facing;
   logic       walking;
   logic [1:0] anim_frame;

   int errors = 0;
   int checks = 0;

   // {tile_x, tile_y, pix_off, anim_frame, walking, facing}
   logic [20:0] exp_q[$];
   logic [20:0] got_v;
   logic [20:0] exp_v;
   wire  [20:0] obs_s = {tile_x, tile_y, pix_off, anim_frame, walking, facing};

   player_step_ctrl #(.MAP_W(40), .MAP_H(30), .START_X(10), .START_Y(10)) dut (
      .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .move_req(move_req),
      .move_dir(move_dir), .run(run), .coll_req(coll_req), .coll_x(coll_x),
      .coll_y(coll_y), .coll_ack(coll_ack), .coll_blocked(coll_blocked),
      .tile_x(tile_x), .tile_y(tile_y), .pix_off(pix_off), .facing(facing),
      .walking(walking), .anim_frame(anim_frame)
   );

   always #5 Clk = ~Clk;

   function automatic logic [20:0] mk(input logic [5:0] tx, input logic [5:0] ty,
                                      input logic [3:0] px, input logic [1:0] an,
                                      input logic wk, input logic [1:0] fc);
      return {tx, ty, px, an, wk, fc};
   endfunction

   task automatic cycle();
      @(negedge Clk);
   endtask

   task automatic tick();
      @(negedge Clk);
      frame_tick = 1'b1;
      @(negedge Clk);
      frame_tick = 1'b0;
   endtask

   task automatic ack(input logic blocked, input logic with_tick);
      @(negedge Clk);
      coll_ack = 1'b1;
      coll_blocked = blocked;
      frame_tick = with_tick;
      @(negedge Clk);
      coll_ack = 1'b0;
      coll_blocked = 1'b0;
      frame_tick = 1'b0;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      cycle();
      cycle();
      exp_q.push_back(mk(6'd10, 6'd10, 4'd0, 2'd0, 1'b0, 2'd0));
      Reset = 1'b0;
      cycle();
      got_v = obs_s;
      exp_v = exp_q.pop_front();
      checks++;
      if (got_v !== exp_v) begin
         errors++;
         $display("FAIL reset_state got=%h exp=%h", got_v, exp_v);
      end
      checks++;
      if (coll_req !== 1'b0) begin
         errors++;
         $display("FAIL reset_coll_req got=%b exp=0", coll_req);
      end
   endtask

   task automatic test_walk();
      move_req = 1'b1;
      move_dir = 2'd3;
      run = 1'b0;
      tick();
      checks++;
      if ({coll_req, coll_x, coll_y, walking} !== {1'b1, 6'd11, 6'd10, 1'b0}) begin
         errors++;
         $display("FAIL walk_lookup got=%b/%0d/%0d/%b exp=1/11/10/0", coll_req, coll_x, coll_y, walking);
      end
      cycle();
      cycle();
      exp_q.push_back(mk(6'd10, 6'd10, 4'd0, 2'd1, 1'b1, 2'd3));
      ack(1'b0, 1'b1);
      got_v = obs_s;
      exp_v = exp_q.pop_front();
      checks++;
      if (got_v !== exp_v || coll_req !== 1'b0) begin
         errors++;
         $display("FAIL walk_ack got=%h req=%b exp=%h req=0", got_v, coll_req, exp_v);
      end
      for (int k = 1; k <= 16; k++) begin
         exp_q.push_back(mk((k < 16) ? 6'd10 : 6'd11, 6'd10, (k < 16) ? 4'(k) : 4'd0,
                            (k < 8) ? 2'd1 : 2'd0, k < 16, 2'd3));
         if (k == 16) move_req = 1'b0;
         tick();
         got_v = obs_s;
         exp_v = exp_q.pop_front();
         checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL walk_tick%0d got=%h exp=%h", k, got_v, exp_v);
         end
      end
   endtask

   task automatic test_run();
      move_req = 1'b1;
      move_dir = 2'd0;
      run = 1'b1;
      tick();
      move_req = 1'b0;
      run = 1'b0;
      cycle();
      exp_q.push_back(mk(6'd11, 6'd10, 4'd0, 2'd2, 1'b1, 2'd0));
      ack(1'b0, 1'b0);
      got_v = obs_s;
      exp_v = exp_q.pop_front();
      checks++;
      if (got_v !== exp_v) begin
         errors++;
         $display("FAIL run_ack got=%h exp=%h", got_v, exp_v);
      end
      for (int k = 1; k <= 8; k++) begin
         exp_q.push_back(mk(6'd11, (k < 8) ? 6'd10 : 6'd11, (k < 8) ? 4'(2 * k) : 4'd0,
                            (k < 4) ? 2'd2 : 2'd0, k < 8, 2'd0));
         tick();
         got_v = obs_s;
         exp_v = exp_q.pop_front();
         checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL run_tick%0d got=%h exp=%h", k, got_v, exp_v);
         end
      end
   endtask

   task automatic test_blocked();
      move_req = 1'b1;
      move_dir = 2'd1;
      tick();
      move_req = 1'b0;
      exp_q.push_back(mk(6'd11, 6'd11, 4'd0, 2'd1, 1'b1, 2'd1));
      ack(1'b1, 1'b0);
      got_v = obs_s;
      exp_v = exp_q.pop_front();
      checks++;
      if (got_v !== exp_v) begin
         errors++;
         $display("FAIL blocked_ack got=%h exp=%h", got_v, exp_v);
      end
      for (int k = 1; k <= 16; k++) begin
         exp_q.push_back(mk(6'd11, 6'd11, 4'd0, (k < 8) ? 2'd1 : 2'd0, k < 16, 2'd1));
         tick();
         got_v = obs_s;
         exp_v = exp_q.pop_front();
         checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL blocked_tick%0d got=%h exp=%h", k, got_v, exp_v);
         end
      end
   endtask

   task automatic test_timeout();
      move_req = 1'b1;
      move_dir = 2'd2;
      tick();
      move_req = 1'b0;
      for (int i = 0; i < 254; i++) cycle();
      checks++;
      if ({coll_req, walking} !== 2'b10) begin
         errors++;
         $display("FAIL timeout_early got req/walk=%b%b exp=10", coll_req, walking);
      end
      cycle();
      checks++;
      if ({coll_req, walking, tile_x, facing} !== {1'b0, 1'b1, 6'd11, 2'd2}) begin
         errors++;
         $display("FAIL timeout_bump got=%b%b x=%0d f=%0d exp=01 x=11 f=2", coll_req, walking, tile_x, facing);
      end
      for (int k = 1; k <= 16; k++) tick();
      checks++;
      if ({walking, tile_x, tile_y} !== {1'b0, 6'd11, 6'd11}) begin
         errors++;
         $display("FAIL timeout_done got=%b %0d,%0d exp=0 11,11", walking, tile_x, tile_y);
      end
   endtask

   task automatic test_back_to_back();
      logic       par;
      logic [5:0] x;
      par = 1'b0;
      x = 6'd11;
      move_req = 1'b1;
      move_dir = 2'd2;
      run = 1'b1;
      for (int s = 0; s < 11; s++) begin
         tick();
         checks++;
         if ({coll_req, coll_x} !== {1'b1, x - 6'd1}) begin
            errors++;
            $display("FAIL b2b_lookup%0d got=%b/%0d exp=1/%0d", s, coll_req, coll_x, x - 6'd1);
         end
         cycle();
         exp_q.push_back(mk(x, 6'd11, 4'd0, par ? 2'd2 : 2'd1, 1'b1, 2'd2));
         ack(1'b0, 1'b0);
         got_v = obs_s;
         exp_v = exp_q.pop_front();
         checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL b2b_start%0d got=%h exp=%h", s, got_v, exp_v);
         end
         x = x - 6'd1;
         par = ~par;
         exp_q.push_back(mk(x, 6'd11, 4'd0, 2'd0, 1'b0, 2'd2));
         for (int k = 0; k < 8; k++) tick();
         got_v = obs_s;
         exp_v = exp_q.pop_front();
         checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL b2b_end%0d got=%h exp=%h", s, got_v, exp_v);
         end
      end
      run = 1'b0;
   endtask

   task automatic test_edge_bump();
      move_req = 1'b1;
      move_dir = 2'd2;
      tick();
      move_req = 1'b0;
      checks++;
      if ({coll_req, walking, facing, anim_frame, tile_x} !== {1'b0, 1'b1, 2'd2, 2'd2, 6'd0}) begin
         errors++;
         $display("FAIL edge_bump_start got=%b%b f=%0d a=%0d x=%0d exp=01 f=2 a=2 x=0",
                  coll_req, walking, facing, anim_frame, tile_x);
      end
      for (int k = 1; k <= 16; k++) begin
         exp_q.push_back(mk(6'd0, 6'd11, 4'd0, (k < 8) ? 2'd2 : 2'd0, k < 16, 2'd2));
         tick();
         got_v = obs_s;
         exp_v = exp_q.pop_front();
         checks++;
         if (got_v !== exp_v || coll_req !== 1'b0) begin
            errors++;
            $display("FAIL edge_bump_tick%0d got=%h req=%b exp=%h req=0", k, got_v, coll_req, exp_v);
         end
      end
   endtask

   task automatic test_reset_mid_step();
      move_req = 1'b1;
      move_dir = 2'd3;
      tick();
      move_req = 1'b0;
      ack(1'b0, 1'b0);
      for (int k = 0; k < 7; k++) tick();
      checks++;
      if ({pix_off, walking, tile_x} !== {4'd7, 1'b1, 6'd0}) begin
         errors++;
         $display("FAIL mid_step_pre got pix=%0d w=%b x=%0d exp pix=7 w=1 x=0", pix_off, walking, tile_x);
      end
      exp_q.push_back(mk(6'd10, 6'd10, 4'd0, 2'd0, 1'b0, 2'd0));
      @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      got_v = obs_s;
      exp_v = exp_q.pop_front();
      checks++;
      if (got_v !== exp_v || coll_req !== 1'b0) begin
         errors++;
         $display("FAIL mid_step_reset got=%h req=%b exp=%h req=0", got_v, coll_req, exp_v);
      end
      exp_q.push_back(mk(6'd10, 6'd10, 4'd0, 2'd0, 1'b0, 2'd0));
      ack(1'b0, 1'b1);
      cycle();
      got_v = obs_s;
      exp_v = exp_q.pop_front();
      checks++;
      if (got_v !== exp_v || coll_req !== 1'b0) begin
         errors++;
         $display("FAIL late_ack got=%h req=%b exp=%h req=0", got_v, coll_req, exp_v);
      end
   endtask

   initial begin
      test_reset();
      test_walk();
      test_run();
      test_blocked();
      test_timeout();
      test_back_to_back();
      test_edge_bump();
      test_reset_mid_step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
